// File: rtl/apb_master_bridge_if.sv
// Request/response channels plus the APB4 bus of apb_master_bridge, bundled as one interface.
interface apb_master_bridge_if #(
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 32
);
  logic                      req_valid;
  logic                      req_ready;
  logic [ADDR_WIDTH-1:0]     req_addr;
  logic                      req_write;
  logic [DATA_WIDTH-1:0]     req_wdata;
  logic [DATA_WIDTH/8-1:0]   req_strb;
  logic                      rsp_valid;
  logic                      rsp_ready;
  logic [DATA_WIDTH-1:0]     rsp_rdata;
  logic                      rsp_slverr;
  logic                      rsp_timeout;
  logic                      psel;
  logic                      penable;
  logic                      pwrite;
  logic [ADDR_WIDTH-1:0]     paddr;
  logic [DATA_WIDTH-1:0]     pwdata;
  logic [DATA_WIDTH/8-1:0]   pstrb;
  logic                      pready;
  logic                      pslverr;
  logic [DATA_WIDTH-1:0]     prdata;

  modport master (
    input  req_valid, req_addr, req_write, req_wdata, req_strb, rsp_ready,
           pready, pslverr, prdata,
    output req_ready, rsp_valid, rsp_rdata, rsp_slverr, rsp_timeout,
           psel, penable, pwrite, paddr, pwdata, pstrb
  );

  modport slave (
    output req_valid, req_addr, req_write, req_wdata, req_strb, rsp_ready,
           pready, pslverr, prdata,
    input  req_ready, rsp_valid, rsp_rdata, rsp_slverr, rsp_timeout,
           psel, penable, pwrite, paddr, pwdata, pstrb
  );
endinterface

// File: rtl/apb_master_bridge.sv
// APB4 requester: one valid/ready request becomes one APB transfer, whose result is
// returned on a valid/ready response channel. Wait states are bounded by TIMEOUT.
module apb_master_bridge #(
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 32,
  parameter int TIMEOUT    = 16
) (
  input logic               pclk,
  input logic               preset,
  apb_master_bridge_if.master bus
);
  localparam int STRB_W = DATA_WIDTH / 8;
  localparam int CNT_W  = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    RESP   = 2'd3
  } state_e;

  state_e                state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  req_ready_q, req_ready_d;
  logic                  psel_q, psel_d;
  logic                  penable_q, penable_d;
  logic                  pwrite_q, pwrite_d;
  logic [ADDR_WIDTH-1:0] paddr_q, paddr_d;
  logic [DATA_WIDTH-1:0] pwdata_q, pwdata_d;
  logic [STRB_W-1:0]     pstrb_q, pstrb_d;
  logic                  rsp_valid_q, rsp_valid_d;
  logic [DATA_WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;
  logic                  rsp_slverr_q, rsp_slverr_d;
  logic                  rsp_timeout_q, rsp_timeout_d;
  logic                  req_fire_s;
  logic                  timeout_s;

  assign bus.req_ready   = req_ready_q & ~preset;
  assign bus.psel        = psel_q;
  assign bus.penable     = penable_q;
  assign bus.pwrite      = pwrite_q;
  assign bus.paddr       = paddr_q;
  assign bus.pwdata      = pwdata_q;
  assign bus.pstrb       = pstrb_q;
  assign bus.rsp_valid   = rsp_valid_q;
  assign bus.rsp_rdata   = rsp_rdata_q;
  assign bus.rsp_slverr  = rsp_slverr_q;
  assign bus.rsp_timeout = rsp_timeout_q;

  assign req_fire_s = bus.req_valid & bus.req_ready;
  // The limit only fires on a stalled cycle, so pready=1 on the last allowed cycle still completes.
  assign timeout_s  = (TIMEOUT > 0) && !bus.pready && (int'(cnt_q) == TIMEOUT - 1);

  // State and registered-output update.
  always_ff @(posedge pclk) begin
    if (preset) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      req_ready_q   <= 1'b0;
      psel_q        <= 1'b0;
      penable_q     <= 1'b0;
      pwrite_q      <= 1'b0;
      paddr_q       <= '0;
      pwdata_q      <= '0;
      pstrb_q       <= '0;
      rsp_valid_q   <= 1'b0;
      rsp_rdata_q   <= '0;
      rsp_slverr_q  <= 1'b0;
      rsp_timeout_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      req_ready_q   <= req_ready_d;
      psel_q        <= psel_d;
      penable_q     <= penable_d;
      pwrite_q      <= pwrite_d;
      paddr_q       <= paddr_d;
      pwdata_q      <= pwdata_d;
      pstrb_q       <= pstrb_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_rdata_q   <= rsp_rdata_d;
      rsp_slverr_q  <= rsp_slverr_d;
      rsp_timeout_q <= rsp_timeout_d;
    end
  end

  // Next-state selection.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (req_fire_s) state_d = SETUP;
        else            state_d = IDLE;
      end
      SETUP:  state_d = ACCESS;
      ACCESS: begin
        if (bus.pready || timeout_s) state_d = RESP;
        else                         state_d = ACCESS;
      end
      RESP: begin
        if (bus.rsp_ready) state_d = IDLE;
        else               state_d = RESP;
      end
      default: state_d = IDLE;
    endcase
  end

  // Output values for the next cycle, derived from the state being entered.
  always_comb begin
    req_ready_d   = (state_d == IDLE);
    psel_d        = (state_d == SETUP) || (state_d == ACCESS);
    penable_d     = (state_d == ACCESS);
    rsp_valid_d   = (state_d == RESP);
    pwrite_d      = pwrite_q;
    paddr_d       = paddr_q;
    pwdata_d      = pwdata_q;
    pstrb_d       = pstrb_q;
    rsp_rdata_d   = rsp_rdata_q;
    rsp_slverr_d  = rsp_slverr_q;
    rsp_timeout_d = rsp_timeout_q;
    cnt_d         = '0;
    if (req_fire_s) begin
      pwrite_d = bus.req_write;
      paddr_d  = bus.req_addr;
      pwdata_d = bus.req_wdata;
      pstrb_d  = bus.req_write ? bus.req_strb : '0;
    end else begin
      pwrite_d = pwrite_q;
    end
    if (state_q == ACCESS) begin
      if (bus.pready) begin
        rsp_rdata_d   = pwrite_q ? '0 : bus.prdata;
        rsp_slverr_d  = bus.pslverr;
        rsp_timeout_d = 1'b0;
      end else if (timeout_s) begin
        rsp_rdata_d   = '0;
        rsp_slverr_d  = 1'b1;
        rsp_timeout_d = 1'b1;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end else begin
      cnt_d = '0;
    end
  end
endmodule

// File: doc/apb_master_bridge.md
Name: apb_master_bridge

Overview:
Parametrised APB4 requester. Converts a valid/ready request channel into single APB transfers and returns each result on a valid/ready response channel. Generalises the fixed 10-bit address / 32-bit data APB types to configurable widths. Adds write strobes, a wait-state timeout, and explicit response back-pressure. Sits between an internal command source (CPU shim, DMA, test sequencer) and a single APB completer such as the dual-port memory.

Parameters:
ADDR_WIDTH, 10, width of req_addr and paddr
DATA_WIDTH, 32, width of data buses; legal values 8, 16, 32, 64
TIMEOUT, 16, maximum consecutive ACCESS cycles with pready low before the bridge aborts; 0 disables the timeout

Ports:
pclk  in  1  clock; all logic on rising edge
preset  in  1  synchronous, active-high reset
req_valid  in  1  request present
req_ready  out  1  bridge can accept a request
req_addr  in  ADDR_WIDTH  transfer address
req_write  in  1  1 = write, 0 = read
req_wdata  in  DATA_WIDTH  write data
req_strb  in  DATA_WIDTH/8  byte-lane write enables
rsp_valid  out  1  response present
rsp_ready  in  1  consumer accepts response
rsp_rdata  out  DATA_WIDTH  read data; 0 for writes and for timeouts
rsp_slverr  out  1  completer error or timeout
rsp_timeout  out  1  transfer aborted by timeout
psel, penable, pwrite  out  1  APB control
paddr  out  ADDR_WIDTH  APB address
pwdata  out  DATA_WIDTH  APB write data
pstrb  out  DATA_WIDTH/8  APB write strobes
pready, pslverr  in  1  APB completer status
prdata  in  DATA_WIDTH  APB read data

Behaviour:
- Interface: one clock (pclk). Reset (preset) is synchronous and active-high.
- FSM states: IDLE, SETUP, ACCESS, RESP. Reset state is IDLE.
- Outputs while preset is high, and on the first cycle after it, are all 0: req_ready, psel, penable, pwrite, paddr, pwdata, pstrb, rsp_valid, rsp_rdata, rsp_slverr, rsp_timeout. Internal wait counter resets to 0.
- IDLE:
  - req_ready = 1, except while preset is high.
  - On req_valid & req_ready, register addr, write, wdata and strb, then go to SETUP.
  - pstrb is the registered strb for writes and is forced to 0 for reads.
- SETUP:
  - psel = 1, penable = 0; paddr, pwrite, pwdata and pstrb show the registered values.
  - pready is ignored.
  - Unconditional transition to ACCESS.
- ACCESS:
  - psel = 1, penable = 1; address, control and data are held stable.
  - If pready = 1: rsp_rdata = prdata for reads (0 for writes), rsp_slverr = pslverr, rsp_timeout = 0; go to RESP.
  - If pready = 0: increment the wait counter.
  - If TIMEOUT > 0 and the counter reaches TIMEOUT: go to RESP with rsp_slverr = 1, rsp_timeout = 1, rsp_rdata = 0.
  - The counter clears on leaving ACCESS.
- RESP:
  - psel = 0, penable = 0; rsp_valid = 1 and response fields are held stable.
  - On rsp_ready, go to IDLE.
  - rsp_valid must not drop before the handshake.
- Bus fields outside SETUP/ACCESS: paddr, pwrite, pwdata and pstrb hold their last values. Only psel and penable qualify the bus.
- Latency:
  - Request accepted at edge N.
  - SETUP during cycle N+1, first ACCESS cycle N+2.
  - With zero wait states, rsp_valid is asserted in cycle N+3.
  - Minimum request-to-request period is 4 cycles.
- One transfer outstanding at a time; req_ready = 0 in SETUP, ACCESS and RESP.
- Counter width is $clog2(TIMEOUT+1), minimum 1.
- A pready/pslverr/prdata change in the same cycle as the timeout limit: pready = 1 wins, giving a normal completion.
- Reset mid-transfer aborts with no response; psel and penable are 0 on the cycle after preset is sampled high.
- pslverr is sampled only when penable & pready.

Test Plan:
- Single write: addr=0x3A5, wdata=0xDEADBEEF, strb=0xF, pready tied 1 -> psel high cycles N+1..N+2, penable high N+2 only, pstrb=0xF; rsp_valid at N+3 with rdata=0, slverr=0.
- Read with 3 wait states: pready low for 3 ACCESS cycles, then prdata=0x12345678 -> 4 ACCESS cycles with stable paddr; rsp_rdata=0x12345678; pstrb=0 throughout.
- Timeout: TIMEOUT=4, pready held 0 -> exactly 4 ACCESS cycles, then psel drops; rsp_slverr=1, rsp_timeout=1, rsp_rdata=0.
- Error plus back-pressure: pslverr=1 with pready=1, rsp_ready held 0 for 5 cycles -> rsp_valid held 5+ cycles with slverr=1 and fields stable; req_ready=0 throughout.
- Reset during ACCESS: preset high for 1 cycle while waiting -> next cycle psel=0, penable=0, rsp_valid=0; a new request is accepted normally afterwards.
- Parametrised build: ADDR_WIDTH=16, DATA_WIDTH=64, strb=0x0F write -> pstrb=0x0F, 64-bit pwdata correct; back-to-back requests are spaced 4 cycles apart.
